// File: rtl/mac_snd_pkg.sv
// ---------------------------------------------------------------------------
// mac_snd_pkg
//
// Shared constants, types and helpers for the Mac sound output path.
//   SND_OFFSET   : offset-binary to two's-complement flip for buffer bytes
//   PCM_OFFSET   : two's-complement to offset-binary flip for the DAC
//   GAIN_SHIFT   : left shift that puts (sample * gain) at 16-bit full scale
//   DEFAULT_*    : default parameter values for mac_sound_out
//   sndStageValid_t : per-stage valid flags of the three-stage pipeline
//   scaleSample  : centre a raw sample byte and apply the VIA volume
// ---------------------------------------------------------------------------
package mac_snd_pkg;

    localparam logic [7:0]  SND_OFFSET           = 8'h80;
    localparam logic [15:0] PCM_OFFSET           = 16'h8000;
    localparam int          GAIN_SHIFT           = 5;
    localparam int          DEFAULT_RAMP_BITS    = 5;
    localparam int          DEFAULT_TIMEOUT_BITS = 12;

    // One valid bit per pipeline stage: capture, scale, output.
    typedef struct packed {
        logic s1;
        logic s2;
        logic s3;
    } sndStageValid_t;

    // Sound buffer bytes are offset binary (0x80 = silence). The byte is
    // centred, multiplied by (vol + 1) in 1..8, then shifted up so that
    // +127 * 8 lands at 32512 and -128 * 8 at -32768 without saturation.
    function automatic logic signed [15:0] scaleSample(
        input logic [7:0] raw,
        input logic [2:0] vol
    );
        logic [7:0]         centred;
        logic signed [15:0] sample16;
        logic signed [15:0] gain16;
        logic signed [15:0] product;
        centred  = raw ^ SND_OFFSET;
        sample16 = $signed({{8{centred[7]}}, centred});
        gain16   = $signed({13'd0, vol} + 16'd1);
        product  = sample16 * gain16;
        return product <<< GAIN_SHIFT;
    endfunction

endpackage

// File: rtl/mac_sound_out_if.sv
// ---------------------------------------------------------------------------
// mac_sound_out_if
//
// Sound-slot memory bus between the address controller and the sound
// output block.
//   loadSound   : high for the whole sound memory slot
//   memoryLatch : high in the clk where memoryData is valid
//   memoryData  : 16-bit RAM read data
// Modports: master = address controller side, slave = sound consumer.
// ---------------------------------------------------------------------------
interface mac_sound_out_if;

    logic        loadSound;
    logic        memoryLatch;
    logic [15:0] memoryData;

    modport master (
        output loadSound,
        output memoryLatch,
        output memoryData
    );

    modport slave (
        input loadSound,
        input memoryLatch,
        input memoryData
    );

endinterface

// File: rtl/snd_sigma_delta.sv
// ---------------------------------------------------------------------------
// snd_sigma_delta
//
// First-order sigma-delta modulator producing a 1-bit DAC stream whose mean
// duty equals level / 65536.
//   clk     : system clock
//   _reset  : synchronous active-low reset
//   level   : 16-bit unsigned (offset-binary) input level
//   bitOut  : registered 1-bit output stream
// ---------------------------------------------------------------------------
module snd_sigma_delta (
    input  logic        clk,
    input  logic        _reset,
    input  logic [15:0] level,
    output logic        bitOut
);

    // Bit 16 is the carry out of the previous add; it is dropped before the
    // next add so the accumulator behaves as a 16-bit modulo integrator.
    logic [16:0] accReg;

    always_ff @(posedge clk) begin
        if (!_reset) begin
            accReg <= '0;
            bitOut <= 1'b0;
        end else begin
            accReg <= {1'b0, accReg[15:0]} + {1'b0, level};
            bitOut <= accReg[16];
        end
    end

endmodule

// File: rtl/mac_sound_out.sv
// ---------------------------------------------------------------------------
// mac_sound_out
//
// Consumer of the address controller's sound slot. Captures the word read
// from the sound buffer (high byte = audio sample, low byte = disk-speed PWM),
// applies the VIA volume and a click-free mute ramp, and outputs signed PCM
// plus a sigma-delta 1-bit DAC stream.
//
// Ports:
//   clk         : system clock (same as the address controller)
//   _reset      : synchronous active-low reset
//   mem         : sound-slot bus (loadSound, memoryLatch, memoryData)
//   snd_vol     : VIA PA[2:0] volume 0..7
//   _snd_en     : VIA PB7, 0 = sound enabled
//   pcm_out     : signed 16-bit PCM sample
//   pcm_valid   : one-clk strobe when pcm_out updates
//   dac_out     : sigma-delta bitstream
//   disk_pwm    : last captured disk-speed byte
//   snd_timeout : no sample captured for 2^TIMEOUT_BITS-1 clks
//
// Pipeline: S1 capture, S2 scale + ramp step, S3 ramp multiply. A capture in
// clk T produces pcm_valid in clk T+3; one capture per clk is sustained.
// ---------------------------------------------------------------------------
module mac_sound_out
    import mac_snd_pkg::*;
#(
    parameter int RAMP_BITS    = DEFAULT_RAMP_BITS,
    parameter int TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
    input  logic                clk,
    input  logic                _reset,
    mac_sound_out_if.slave      mem,
    input  logic [2:0]          snd_vol,
    input  logic                _snd_en,
    output logic [15:0]         pcm_out,
    output logic                pcm_valid,
    output logic                dac_out,
    output logic [7:0]          disk_pwm,
    output logic                snd_timeout
);

    localparam int                    RAMP_MAX_INT = 1 << RAMP_BITS;
    localparam logic [RAMP_BITS:0]    RAMP_MAX     = RAMP_MAX_INT[RAMP_BITS:0];
    localparam logic [RAMP_BITS:0]    RAMP_ONE     = {{RAMP_BITS{1'b0}}, 1'b1};
    localparam logic [TIMEOUT_BITS-1:0] WD_FULL    = '1;
    localparam logic [TIMEOUT_BITS-1:0] WD_ONE     = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
    // scaled (16b signed) times ramp (RAMP_BITS+1 unsigned, one sign bit added)
    localparam int                    PROD_W       = 16 + RAMP_BITS + 2;

    logic                       cap;
    sndStageValid_t             validReg;

    // S1 registers
    logic [7:0]                 rawReg;
    logic                       staleReg;

    // S2 registers
    logic signed [15:0]         scaledReg;
    logic [RAMP_BITS:0]         rampReg;
    logic [RAMP_BITS:0]         rampNext;
    logic                       rampUp;

    // S3 datapath
    logic signed [PROD_W-1:0]   scaledWide;
    logic signed [PROD_W-1:0]   rampWide;
    logic signed [PROD_W-1:0]   pcmProduct;
    logic signed [15:0]         pcmNext;

    // Watchdog
    logic [TIMEOUT_BITS-1:0]    wdCountReg;

    logic [15:0]                dacLevel;

    assign cap         = mem.loadSound & mem.memoryLatch;
    assign snd_timeout = (wdCountReg == WD_FULL);
    assign pcm_valid   = validReg.s3;

    // The capture that ends a timeout also clears the watchdog, so by the
    // time that sample reaches S2 snd_timeout is already low. The timeout
    // state seen at capture travels with the sample (staleReg) so a sample
    // arriving after a silence gap is treated as muted.
    always_comb begin
        rampUp   = ~_snd_en & ~staleReg;
        rampNext = rampReg;
        if (rampUp) begin
            if (rampReg != RAMP_MAX) begin
                rampNext = rampReg + RAMP_ONE;
            end
        end else begin
            if (rampReg != '0) begin
                rampNext = rampReg - RAMP_ONE;
            end
        end
    end

    // Full-width signed multiply, then arithmetic shift back down by the
    // ramp resolution; the result always fits 16 bits.
    always_comb begin
        scaledWide = {{(RAMP_BITS + 2){scaledReg[15]}}, scaledReg};
        rampWide   = {17'd0, rampReg};
        pcmProduct = scaledWide * rampWide;
        pcmNext    = 16'(pcmProduct >>> RAMP_BITS);
    end

    always_ff @(posedge clk) begin
        if (!_reset) begin
            validReg   <= '0;
            rawReg     <= '0;
            staleReg   <= 1'b0;
            disk_pwm   <= '0;
            scaledReg  <= '0;
            rampReg    <= '0;
            pcm_out    <= '0;
            wdCountReg <= '0;
        end else begin
            // S1: capture
            validReg.s1 <= cap;
            if (cap) begin
                rawReg   <= mem.memoryData[15:8];
                disk_pwm <= mem.memoryData[7:0];
                staleReg <= snd_timeout;
            end

            // S2: volume scale and one ramp step per sample
            validReg.s2 <= validReg.s1;
            if (validReg.s1) begin
                scaledReg <= scaleSample(rawReg, snd_vol);
                rampReg   <= rampNext;
            end

            // S3: apply ramp
            validReg.s3 <= validReg.s2;
            if (validReg.s2) begin
                pcm_out <= pcmNext;
            end

            // Watchdog: clears on capture, otherwise counts up and holds
            if (cap) begin
                wdCountReg <= '0;
            end else if (wdCountReg != WD_FULL) begin
                wdCountReg <= wdCountReg + WD_ONE;
            end
        end
    end

    // Offset-binary view of the PCM word for the modulator.
    assign dacLevel = pcm_out ^ PCM_OFFSET;

    snd_sigma_delta uDac (
        .clk    (clk),
        ._reset (_reset),
        .level  (dacLevel),
        .bitOut (dac_out)
    );

endmodule

// File: tb/tb_mac_sound_out.sv
// ---------------------------------------------------------------------------
// tb_mac_sound_out
//
// Scoreboard bench for mac_sound_out: each capture pushes the expected PCM
// word (from a small reference model of volume, ramp and watchdog) and its
// capture cycle; the monitor pops on pcm_valid and checks value and latency.
// ---------------------------------------------------------------------------
module tb_mac_sound_out;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [2:0]  sndVol = 3'd0;
    logic        sndEnN = 1'b1;
    logic [15:0] pcmOut;
    logic        pcmValid;
    logic        dacOut;
    logic [7:0]  diskPwm;
    logic        sndTimeout;

    mac_sound_out_if memIf ();

    mac_sound_out dut (
        .clk         (clk),
        ._reset      (rstN),
        .mem         (memIf),
        .snd_vol     (sndVol),
        ._snd_en     (sndEnN),
        .pcm_out     (pcmOut),
        .pcm_valid   (pcmValid),
        .dac_out     (dacOut),
        .disk_pwm    (diskPwm),
        .snd_timeout (sndTimeout)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int idleM       = 0;
    int rampM       = 0;
    bit stepChk     = 1'b0;
    int lastPcm     = 0;

    typedef struct {
        logic [15:0] pcm;
        int          stamp;
    } sbEntry_t;

    sbEntry_t sbQ[$];
    sbEntry_t monE;
    int       monCur;
    int       monDiff;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference watchdog: clks since the last capture, saturating.
    always @(posedge clk) begin
        if (!rstN)
            idleM <= 0;
        else if (memIf.loadSound && memIf.memoryLatch)
            idleM <= 0;
        else if (idleM < 4095)
            idleM <= idleM + 1;
    end

    // Reference model evaluated at the capture clk.
    task automatic pushExpected(input logic [15:0] data);
        int s;
        int scaled;
        int p;
        bit up;
        sbEntry_t e;
        up = !sndEnN && (idleM != 4095);
        if (up && rampM < 32)
            rampM++;
        else if (!up && rampM > 0)
            rampM--;
        s      = int'(data[15:8]) - 128;
        scaled = s * (int'(sndVol) + 1) * 32;
        p      = (scaled * rampM) >>> 5;
        e.pcm   = p[15:0];
        e.stamp = cyc;
        sbQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rstN && pcmValid) begin
            if (sbQ.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                monE = sbQ.pop_front();
                $display("pcm cap@%0d out@%0d pcm_out=0x%04h exp=0x%04h", monE.stamp, cyc, pcmOut, monE.pcm);
                check("pcm", 32'(pcmOut), 32'(monE.pcm));
                check("latency", cyc - monE.stamp, 32'd3);
                monCur = int'($signed(pcmOut));
                if (stepChk) begin
                    monDiff = (monCur > lastPcm) ? monCur - lastPcm : lastPcm - monCur;
                    check("step_le_1016", 32'(monDiff > 1016), 32'd0);
                end
                lastPcm = monCur;
            end
        end
    end

    // One sound slot: loadSound for 4 clks, data latched in the second.
    task automatic soundSlot(input logic [15:0] data);
        for (int k = 0; k < 4; k++) begin
            memIf.loadSound   = 1'b1;
            memIf.memoryLatch = (k == 1);
            memIf.memoryData  = data;
            if (k == 1) pushExpected(data);
            @(posedge clk); #1;
        end
        memIf.loadSound   = 1'b0;
        memIf.memoryLatch = 1'b0;
    endtask

    // Back-to-back captures, one per clk.
    task automatic burst(input logic [15:0] data, input int n);
        for (int k = 0; k < n; k++) begin
            memIf.loadSound   = 1'b1;
            memIf.memoryLatch = 1'b1;
            memIf.memoryData  = data;
            pushExpected(data);
            @(posedge clk); #1;
        end
        memIf.loadSound   = 1'b0;
        memIf.memoryLatch = 1'b0;
    endtask

    // memoryLatch outside a sound slot must not capture.
    task automatic strayLatch();
        memIf.loadSound   = 1'b0;
        memIf.memoryLatch = 1'b1;
        memIf.memoryData  = 16'h1234;
        @(posedge clk); #1;
        memIf.memoryLatch = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
    endtask

    task automatic countOnes(output int ones);
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (dacOut) ones++;
        end
    endtask

    int  guard;
    int  ones;
    logic prevDac;

    initial begin
        memIf.loadSound   = 1'b0;
        memIf.memoryLatch = 1'b0;
        memIf.memoryData  = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pcm_out", 32'(pcmOut), 32'd0);
        check("rst_pcm_valid", 32'(pcmValid), 32'd0);
        check("rst_dac_out", 32'(dacOut), 32'd0);
        check("rst_disk_pwm", 32'(diskPwm), 32'd0);
        check("rst_timeout", 32'(sndTimeout), 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;

        // Ramp up 10 steps then reverse for 4
        sndVol = 3'd7; sndEnN = 1'b0; stepChk = 1'b1; lastPcm = 0;
        repeat (10) soundSlot(16'hFF00);
        sndEnN = 1'b1;
        repeat (4) soundSlot(16'hFF00);
        drain();
        check("reversal_final", 32'(pcmOut), 32'd6096);
        stepChk = 1'b0;

        // Full-scale positive, slots then back-to-back
        sndEnN = 1'b0;
        repeat (20) soundSlot(16'hFF40);
        burst(16'hFF40, 20);
        drain();
        check("pos_full_pcm", 32'(pcmOut), 32'h7F00);
        check("pos_disk_pwm", 32'(diskPwm), 32'h40);
        strayLatch();
        drain();

        // Full-scale negative
        sndVol = 3'd0;
        soundSlot(16'h0012);
        drain();
        check("neg_full_pcm", 32'(pcmOut), 32'hF000);
        check("neg_disk_pwm", 32'(diskPwm), 32'h12);

        // Watchdog
        sndVol = 3'd7;
        guard = 0;
        while (idleM != 4094 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("timeout_before_sat", 32'(sndTimeout), 32'd0);
        @(negedge clk);
        check("timeout_sat", 32'(sndTimeout), 32'd1);
        @(posedge clk); #1;
        memIf.loadSound   = 1'b1;
        memIf.memoryLatch = 1'b1;
        memIf.memoryData  = 16'hFF40;
        check("timeout_at_cap", 32'(sndTimeout), 32'd1);
        pushExpected(16'hFF40);
        @(posedge clk); #1;
        memIf.loadSound   = 1'b0;
        memIf.memoryLatch = 1'b0;
        @(negedge clk);
        check("timeout_cleared", 32'(sndTimeout), 32'd0);
        drain();
        check("timeout_rampdown", 32'(pcmOut), 32'd31496);
        burst(16'hFF40, 4);
        drain();

        // DAC at mid-scale: strict alternation and 50% duty
        soundSlot(16'h8000);
        drain();
        check("dac_mid_pcm", 32'(pcmOut), 32'd0);
        repeat (6) @(negedge clk);
        prevDac = dacOut;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("dac_alternate", 32'(dacOut), 32'(!prevDac));
            prevDac = dacOut;
        end
        countOnes(ones);
        $display("dac duty mid-scale ones=%0d/1024", ones);
        check("dac_duty_50", 32'(ones >= 511 && ones <= 513), 32'd1);

        // DAC at 0x4000: 75% duty
        soundSlot(16'hC000);
        drain();
        check("dac_q_pcm", 32'(pcmOut), 32'h4000);
        repeat (6) @(negedge clk);
        countOnes(ones);
        $display("dac duty 0x4000 ones=%0d/1024", ones);
        check("dac_duty_75", 32'(ones >= 766 && ones <= 770), 32'd1);

        // Reset mid-stream with a capture in the reset clk
        burst(16'hFF40, 2);
        rstN = 1'b0;
        memIf.loadSound   = 1'b1;
        memIf.memoryLatch = 1'b1;
        memIf.memoryData  = 16'hFF55;
        sbQ.delete();
        rampM = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_pcm_out", 32'(pcmOut), 32'd0);
            check("midrst_pcm_valid", 32'(pcmValid), 32'd0);
            check("midrst_dac_out", 32'(dacOut), 32'd0);
        end
        check("midrst_disk_pwm", 32'(diskPwm), 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        memIf.loadSound   = 1'b0;
        memIf.memoryLatch = 1'b0;

        // Ramp restarts from zero
        repeat (4) soundSlot(16'hFF40);
        drain();
        check("post_rst_pcm", 32'(pcmOut), 32'd4064);
        check("sb_drain", 32'(sbQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
